// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants shared by the UART transmitter and receiver:
//                character size, frame length and the 2-bit encodings of
//                the framing state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Data bits per character
    localparam int DATA_BITS  = 8;
    // start + data + stop
    localparam int FRAME_BITS = 10;

    // Framing state machine encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Single-clock show-ahead FIFO for the UART transmitter.
//                o_data always presents the oldest entry. A pop on an empty
//                FIFO and a push on a full FIFO are ignored.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                i_push, i_data - write strobe and data
//                i_pop          - remove the oldest entry
//                o_data         - oldest entry (valid when !o_empty)
//                o_full/o_empty - occupancy flags
//                o_level        - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_full_lvl = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_level == c_full_lvl);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter with a small transmit FIFO. Sends 8N1
//                frames (start 0, 8 data bits LSB first, stop 1), one bit
//                per clk_uart strobe. Frames run back to back while bytes
//                are queued.
//  Ports       : clk      - system clock
//                rst_n    - async active-low reset
//                clk_uart - one-clk baud strobe per bit period
//                tx_data  - byte to send, sampled on tx_valid & tx_ready
//                tx_valid - tx_data valid
//                tx_ready - FIFO not full
//                txd      - serial line (registered, idle high)
//                tx_busy  - frame in progress or bytes queued
//                tx_done  - one-clk pulse at the end of each stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_uart,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

    logic [1:0]              r_state;
    logic [DATA_BITS-1:0]    r_shift;
    logic [2:0]              r_bit_idx;
    logic                    r_txd;
    logic                    r_done;

    logic                    w_push;
    logic                    w_pop;
    logic [DATA_BITS-1:0]    w_fifo_data;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_level;

    // A byte leaves the FIFO only on a strobe that begins a new frame:
    // from IDLE, or at the end of a stop bit for a gapless next frame.
    assign w_push = tx_valid & ~w_fifo_full;
    assign w_pop  = clk_uart & ~w_fifo_empty &
                    ((r_state == IDLE) | (r_state == STOP));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign tx_ready = ~w_fifo_full;
    assign txd      = r_txd;
    assign tx_done  = r_done;
    assign tx_busy  = (r_state != IDLE) | (w_fifo_level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clk_uart) begin
                case (r_state)
                    IDLE: begin
                        if (!w_fifo_empty) begin
                            r_shift <= w_fifo_data;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end
                    end
                    START: begin
                        // Shift right so r_shift[0] is always the next bit.
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                    DATA: begin
                        if (r_bit_idx == c_last_bit) begin
                            r_txd     <= 1'b1;
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    STOP: begin
                        r_done <= 1'b1;
                        if (!w_fifo_empty) begin
                            r_shift <= w_fifo_data;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_txd   <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Accepted bytes go into a
//                scoreboard queue; a line monitor deserialises txd on each
//                strobe and pops/compares every completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       clk_uart = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    // Strobe generator control: div = 0 holds clk_uart low
    int div  = 0;
    int scnt = 0;
    int cyc  = 0;

    // Line monitor state
    int         mon_pos    = 0;   // 0 idle, 1..9 bits sampled, 10 in stop bit
    logic [9:0] cur_frame  = '0;
    logic [9:0] last_frame = '0;
    int         start_cyc  = 0;
    int         last_dur   = 0;
    int         n_done     = 0;
    int         n_start    = 0;
    int         n_b2b      = 0;
    logic       last_txd   = 1'b1;

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_uart (clk_uart),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor and strobe generator share one negedge process so the strobe
    // value seen by the monitor is the one the DUT captured at the posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mon_pos  = 0;
                exp_q.delete();
                last_txd = txd;
            end else begin
                if (clk_uart) begin
                    check("done_pulse", 32'(tx_done), 32'(mon_pos == 10));
                    if (mon_pos == 10) begin
                        n_done++;
                        last_dur = cyc - start_cyc;
                    end
                    if (mon_pos == 0 || mon_pos == 10) begin
                        if (txd == 1'b0) begin
                            if (mon_pos == 10) n_b2b++;
                            n_start++;
                            mon_pos   = 1;
                            start_cyc = cyc;
                            cur_frame = '0;
                        end else begin
                            mon_pos = 0;
                        end
                    end else begin
                        cur_frame[mon_pos] = txd;
                        if (mon_pos == 9) begin
                            check("stop_bit", 32'(txd), 32'd1);
                            last_frame = cur_frame;
                            if (exp_q.size() == 0)
                                check("sb_unexpected", 32'(exp_q.size()), 32'd1);
                            else
                                check("sb_byte", 32'(cur_frame[8:1]), 32'(exp_q.pop_front()));
                            mon_pos = 10;
                        end else begin
                            mon_pos++;
                        end
                    end
                end else begin
                    check("txd_hold", 32'(txd), 32'(last_txd));
                    check("done_idle", 32'(tx_done), 32'd0);
                end
                last_txd = txd;
            end
            if (div == 0) begin
                clk_uart = 1'b0;
                scnt     = 0;
            end else if (scnt + 1 >= div) begin
                clk_uart = 1'b1;
                scnt     = 0;
            end else begin
                clk_uart = 1'b0;
                scnt++;
            end
        end
    end

    // Present a byte and hold it until accepted; record it on the handshake.
    task automatic send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            check("send_timeout", 32'(tx_ready), 32'd1);
        end else begin
            exp_q.push_back(d);
            @(posedge clk);
        end
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy && n < max);
        check("idle_timeout", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    int d0;
    int b0;
    int s0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd",   32'(txd),      32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",  32'(tx_busy),  32'd0);
        check("rst_done",  32'(tx_done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_txd",  32'(txd),     32'd1);
        check("post_rst_busy", 32'(tx_busy), 32'd0);

        // Single byte 0xA5 at 16 clks per bit; no bypass before a strobe
        div = 0;
        d0  = n_done;
        send(8'hA5);
        @(negedge clk);
        #1;
        check("t1_nobypass_txd", 32'(txd),     32'd1);
        check("t1_busy_queued",  32'(tx_busy), 32'd1);
        div = 16;
        wait_idle(400);
        check("t1_frame", 32'(last_frame), 32'(10'b1101001010));
        check("t1_dur",   32'(last_dur),   32'd160);
        check("t1_done",  32'(n_done - d0), 32'd1);
        check("t1_idle_txd", 32'(txd), 32'd1);

        // Back-to-back 0x00, 0xFF with no idle bit between frames
        div = 0;
        d0  = n_done;
        b0  = n_b2b;
        send(8'h00);
        send(8'hFF);
        div = 16;
        wait_idle(800);
        check("t2_done",  32'(n_done - d0), 32'd2);
        check("t2_b2b",   32'(n_b2b - b0),  32'd1);
        check("t2_frame", 32'(last_frame),  32'(10'b1111111110));
        check("t2_dur",   32'(last_dur),    32'd160);

        // Fill FIFO with strobes held off; 5th waits for the first pop
        div = 0;
        d0  = n_done;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        @(negedge clk);
        #1;
        check("t3_ready_full", 32'(tx_ready), 32'd0);
        check("t3_txd_idle",   32'(txd),      32'd1);
        fork
            send(8'h14);
            begin
                repeat (4) @(negedge clk);
                div = 16;
            end
        join
        wait_idle(2000);
        check("t3_done",  32'(n_done - d0),   32'd5);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 3 of 0x3C with two bytes queued
        div = 0;
        send(8'h3C);
        send(8'h11);
        send(8'h22);
        div = 16;
        begin
            int n = 0;
            while (mon_pos != 5 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_reach_bit3", 32'(mon_pos), 32'd5);
        @(negedge clk);
        #1;
        check("t4_busy_mid", 32'(tx_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_txd",   32'(txd),      32'd1);
        check("t4_rst_busy",  32'(tx_busy),  32'd0);
        check("t4_rst_ready", 32'(tx_ready), 32'd1);
        check("t4_rst_done",  32'(tx_done),  32'd0);
        s0 = n_start;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        check("t4_no_frames", 32'(n_start - s0), 32'd0);
        check("t4_txd_high",  32'(txd),          32'd1);
        check("t4_busy_low",  32'(tx_busy),      32'd0);

        // Strobe every clk: a frame lasts 10 clks
        div = 0;
        d0  = n_done;
        send(8'h81);
        div = 1;
        wait_idle(100);
        check("t5_frame", 32'(last_frame),  32'(10'b1100000010));
        check("t5_dur",   32'(last_dur),    32'd10);
        check("t5_done",  32'(n_done - d0), 32'd1);

        // Keep pushing into a full FIFO while it drains: order preserved
        div = 0;
        d0  = n_done;
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
        div = 2;
        for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i));
        wait_idle(1000);
        check("t6_done",     32'(n_done - d0),   32'd10);
        check("t6_sb_empty", 32'(exp_q.size()),  32'd0);
        check("t6_frame",    32'(last_frame),    32'(10'b1110001010));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port clk_uart  input  1  baud strobe, one clk-wide pulse per bit period.
REQ-005 SHALL have port tx_data  input  8  byte to send.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port tx_ready  output  1  byte accepted when tx_valid & tx_ready.
REQ-008 SHALL have port txd  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port tx_done  output  1  one-clk pulse at end of each stop bit.

Function
REQ-011 SHALL send a 10-bit frame: start bit 0, data bits 0..7 (LSB first), stop bit 1.
REQ-012 SHALL hold each bit for exactly one clk_uart interval; txd changes only on the clk after a clk_uart strobe.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: txd=1; on a clk_uart strobe with FIFO non-empty, SHALL pop one byte into the shift register, drive txd=0 and enter START.
REQ-015 START: on the next strobe, SHALL drive bit0 and enter DATA with bit index 0.
REQ-016 DATA: each strobe SHALL advance the index; after bit7's interval SHALL drive txd=1 and enter STOP.
REQ-017 STOP: on the strobe ending the stop bit, SHALL pulse tx_done for one clk; if FIFO is non-empty, SHALL pop and enter START in the same cycle (no idle gap), else enter IDLE.
REQ-018 The bit index SHALL be 3 bits and SHALL wrap only via the DATA->STOP transition.
REQ-019 tx_ready SHALL equal not-FIFO-full; a push when full SHALL NOT occur.
REQ-020 A simultaneous push and pop SHALL keep the FIFO level unchanged, preserving order.
REQ-021 A push into an empty FIFO SHALL NOT bypass to the line; transmission starts at the next eligible strobe.
REQ-022 tx_valid without tx_ready SHALL be held by the sender; tx_data SHALL be sampled only on the handshake cycle.
REQ-023 txd SHALL be driven directly from a flop (glitch-free).
REQ-024 Strobes arriving on consecutive clks SHALL be legal (one bit per clk).

Reset
REQ-025 On rst_n low, SHALL set txd=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, and FIFO empty, asynchronously.
REQ-026 Reset mid-frame SHALL abort the frame and discard all queued bytes; txd SHALL return high with no further edges.
REQ-027 The first frame after reset release SHALL start only on a strobe following a valid push.

Structure
REQ-028 SHALL place FSM state encodings, DATA_BITS=8 and the frame length of 10 in a shared package, uart_pkg, also usable by uart_rx.
REQ-029 The FIFO SHALL be one sub-module, uart_tx_fifo (synchronous, single clock, with full/empty flags and a level output).
REQ-030 The RTL SHALL total 120-400 lines.

Verification
REQ-031 Single byte 0xA5, strobe every 16 clks -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 16 clks; tx_done pulses once; then idle high.
REQ-032 Back-to-back 0x00 then 0xFF -> 20 contiguous bit periods with no idle bit between the stop and the next start; tx_done pulses twice.
REQ-033 clk_uart held low, tx_valid held with 5 bytes -> 4 accepted, tx_ready=0 on the 5th; after the first pop the 5th is accepted; all 5 bytes are sent in order.
REQ-034 Assert rst_n low during data bit 3 of 0x3C with 2 bytes queued -> txd=1 immediately; no further frames; tx_busy=0, tx_ready=1.
REQ-035 clk_uart high every clk, byte 0x81 -> a frame lasts 10 clks: 0,1,0,0,0,0,0,0,1,1.
REQ-036 Push while the FIFO is full and a pop occurs in the same cycle -> the level stays 4 and no byte is lost or duplicated.
